param_fifo: RTL
===============

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 8, SHALL set the data bits per entry (legal 1..32).
REQ-002 Parameter ADDR_WIDTH, 5, SHALL set depth DEPTH = 2**ADDR_WIDTH (legal 1..10).
REQ-003 Parameter AF_LEVEL, 28, SHALL set the almost_full threshold (legal 1..DEPTH).
REQ-004 Parameter AE_LEVEL, 4, SHALL set the almost_empty threshold (legal 0..DEPTH-1).
REQ-005 Port clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-006 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 Port wr_en  input  1  SHALL be the write request.
REQ-008 Port wr_data  input  DATA_WIDTH  SHALL be the write data.
REQ-009 Port rd_en  input  1  SHALL be the read (pop) request.
REQ-010 Port rd_data  output  DATA_WIDTH  SHALL carry the oldest stored entry (first-word fall-through).
REQ-011 Port clr_err  input  1  SHALL clear the sticky error flags.
REQ-012 Port count  output  ADDR_WIDTH+1  SHALL give the stored entry count, 0..DEPTH.
REQ-013 Ports empty, full, almost_empty, almost_full, overflow, underflow  output  1 each  SHALL be the status flags.

Function
REQ-014 empty SHALL be 1 iff count==0; full SHALL be 1 iff count==DEPTH; both combinational from count.
REQ-015 almost_full SHALL be 1 iff count>=AF_LEVEL; almost_empty SHALL be 1 iff count<=AE_LEVEL.
REQ-016 Write accept SHALL be wr_en && (!full || rd_accept); the entry is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-017 Read accept SHALL be rd_en && !empty; rd_ptr increments modulo DEPTH.
REQ-018 Simultaneous accepted read and write SHALL leave count unchanged; write-only +1; read-only -1.
REQ-019 When full, simultaneous rd_en and wr_en SHALL both be accepted (no overflow).
REQ-020 When empty, simultaneous rd_en and wr_en SHALL accept the write only and flag underflow.
REQ-021 rd_data SHALL equal mem[rd_ptr] combinationally when !empty, and all-zero when empty.
REQ-022 A written entry SHALL appear on rd_data the cycle after the accepting edge (write-to-read latency 1).
REQ-023 overflow SHALL be sticky: set on any edge with wr_en && !write_accept.
REQ-024 underflow SHALL be sticky: set on any edge with rd_en && empty.
REQ-025 clr_err SHALL clear both sticky flags on the next edge; a set condition on the same edge SHALL win.
REQ-026 Rejected writes and reads SHALL not modify memory, pointers or count.

Reset
REQ-027 Asserting reset SHALL immediately clear wr_ptr, rd_ptr, count, overflow and underflow, independent of clk.
REQ-028 During reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0, i.e. 0), rd_data=0; memory contents SHALL be left uncleared.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; the first edge after deassertion SHALL behave as from empty.

Configuration
REQ-030 Macro PARAM_FIFO_STATS_EN defined SHALL add outputs wr_total and rd_total (32 bits each), counting accepted writes/reads, wrapping at 2**32, cleared by reset.
REQ-031 Macro PARAM_FIFO_STATS_EN undefined SHALL omit those ports and counters entirely; all other behaviour identical.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 Write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_empty drops at count 2; almost_full at 3; full at 4; rd_data=0x11 one cycle after first write.
REQ-033 Full, wr_en=1 with 0x55, rd_en=0 -> overflow=1, count stays 4, then 4 pops return 0x11,0x22,0x33,0x44, empty=1, rd_data=0.
REQ-034 Full, rd_en=wr_en=1 with 0x66 -> both accepted, count 4, overflow stays 0, rd_data next=0x22; 0x66 read last after wrap.
REQ-035 Empty, rd_en=wr_en=1 with 0x77 -> underflow=1, count 1, rd_data=0x77; clr_err pulse -> underflow=0.
REQ-036 Count 3, assert reset between edges -> count, flags, rd_data go 0/empty asynchronously; after release write 0x88 -> rd_data 0x88, count 1.
REQ-037 With PARAM_FIFO_STATS_EN, REQ-032 then 4 pops -> wr_total=4, rd_total=4; rejected operations not counted.

Source files
------------

// File: rtl/param_fifo.sv
// Parameterised first-word fall-through FIFO with almost-full/empty thresholds
// and sticky overflow/underflow flags. Define PARAM_FIFO_STATS_EN to add
// the wr_total/rd_total accepted-transfer counters.
`default_nettype none

module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
`ifdef PARAM_FIFO_STATS_EN
  ,
  output logic [31:0]           wr_total,
  output logic [31:0]           rd_total
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_CNT);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write
  // alongside a read; an empty FIFO never pops, even with a concurrent write.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_accept && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A new error on the same edge as clr_err takes priority over the clear.
      if (wr_en && !wr_accept) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef PARAM_FIFO_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_total <= '0;
      rd_total <= '0;
    end else begin
      if (wr_accept) begin
        wr_total <= wr_total + 32'd1;
      end
      if (rd_accept) begin
        rd_total <= rd_total + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
